feature_rd_seq: RTL
===================

# feature_rd_seq

Downstream consumer of the bank-enable decoder in the feature-fetch path. It takes one fetch descriptor: a bank enable vector plus in-bank start and stop offsets. It walks the 8×512-entry banked feature RAM in ascending feature order, issuing one read per cycle. Returned words are streamed to the aggregation datapath through a 2-entry output buffer with valid/ready backpressure.

## Interface
- DATA_W, 16, width of one feature word per bank
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  descriptor valid pulse; sampled only in IDLE
- bank_en  in  8  bank enable vector, bit b = bank b (features b*512..b*512+511)
- ram_start  in  9  start offset inside first enabled bank
- ram_stop  in  9  stop offset (inclusive) inside last enabled bank
- ram_en  out  8  one-hot bank read enable, 0 when no read issued
- ram_addr  out  9  in-bank read address, valid when ram_en != 0
- ram_rdata  in  8*DATA_W  bank read data, bank b at [b*DATA_W +: DATA_W]; 1-cycle read latency
- feat_valid  out  1  output word valid
- feat_ready  in  1  consumer ready
- feat_data  out  DATA_W  feature word
- feat_idx  out  12  global feature index = bank*512 + addr
- feat_last  out  1  marks final word of descriptor
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at descriptor completion
- err  out  1  valid with done; descriptor rejected, no reads issued

## Operation
- start in IDLE latches bank_en, ram_start and ram_stop. first = lowest set bit of bank_en; last = highest set bit.
- Banks first..last are all walked, including clear bits between them. Gaps are filled, not skipped.
- Address ranges:
  - first bank: ram_start..511
  - middle banks: 0..511
  - last bank: 0..ram_stop
  - first == last: ram_start..ram_stop
- Error: bank_en == 0, or first == last with ram_stop < ram_start. Goes to DONE with err=1; no ram_en assertion.
- States:
  - IDLE: start → RUN, or → DONE if error.
  - RUN: issue reads; after last address issued → DRAIN.
  - DRAIN: wait until buffer empty and no read in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Issue rule: read issued in a cycle iff state is RUN and (count + inflight − pop) < 2.
  - count = buffer occupancy, 0..2
  - inflight = read issued in the previous cycle
  - pop = feat_valid && feat_ready
- Address counter: 9-bit. On reaching the bank end, the address wraps to 0 and the bank increments. No wrap past bank 7.
- Read data is selected by the bank registered at issue. It is written into the buffer together with feat_idx and feat_last.
- Buffer is in-order, 2 entries, never overflows under the issue rule. Simultaneous push and pop holds count.
- start while busy: ignored.
- Reset in any state:
  - state → IDLE
  - buffer cleared
  - any in-flight read is discarded, and its returning data is not captured in the following cycle

## Timing
- Reset values: ram_en=0, ram_addr=0, feat_valid=0, feat_data=0, feat_idx=0, feat_last=0, busy=0, done=0, err=0.
- Start accepted in cycle 0. busy=1 from cycle 1. First ram_en in cycle 1, data on ram_rdata in cycle 2, feat_valid=1 in cycle 3.
- Throughput: 1 word/cycle while feat_ready is held high.
- feat_valid/feat_data/feat_idx/feat_last hold stable while feat_valid && !feat_ready.
- done (and err) pulse the cycle after the last beat is accepted; busy falls in the same cycle.
- Error path: done=err=1 in cycle 1 after start; busy is never asserted.
- N words total: done no earlier than cycle N+3 with feat_ready constantly high.

## Test plan
- bank_en=8'b0000_0100, start=10, stop=13 → 4 beats, idx 1034..1037, ram_en=8'b0000_0100, feat_last on idx 1037.
- bank_en=8'b0000_0111, start=500, stop=6 → 531 contiguous beats idx 500..1030. Bank steps 0→1 at addr 511→0 and 1→2 at idx 1024.
- bank_en=8'hFF, start=0, stop=511 → 4096 beats idx 0..4095, no bubbles, done at cycle 4099.
- Same as case 2 with feat_ready toggled pseudo-randomly → identical sequence, no loss or duplication, count never exceeds 2.
- bank_en=0 → done=err=1 in cycle 1, ram_en stays 0. bank_en=8'b0001_0000, start=20, stop=5 → same error response.
- rst asserted mid-RUN with a read in flight → all outputs at reset values next cycle, no stale feat_valid. A new start then runs correctly.

Source files
------------

// File: rtl/feature_rd_seq.sv
// feature_rd_seq: walks the 8x512 banked feature RAM for one fetch descriptor,
// issuing one read per cycle. Returned words go out through a 2-entry in-order
// buffer with valid/ready handshaking.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_bank_en,           descriptor: start pulse, bank enable vector,
//   i_ram_start, i_ram_stop       start offset in first bank, stop offset in last bank
//   o_ram_en, o_ram_addr          one-hot bank read enable and in-bank address
//   i_ram_rdata                   bank read data, 1-cycle latency
//   o_feat_valid, i_feat_ready    output handshake
//   o_feat_data, o_feat_idx,      feature word, global index, last-word marker
//   o_feat_last
//   o_busy, o_done, o_err         status: busy, completion pulse, rejected descriptor
module feature_rd_seq #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_bank_en,
    input  logic [8:0]            i_ram_start,
    input  logic [8:0]            i_ram_stop,
    output logic [7:0]            o_ram_en,
    output logic [8:0]            o_ram_addr,
    input  logic [8*DATA_W-1:0]   i_ram_rdata,
    output logic                  o_feat_valid,
    input  logic                  i_feat_ready,
    output logic [DATA_W-1:0]     o_feat_data,
    output logic [11:0]           o_feat_idx,
    output logic                  o_feat_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int unsigned ENT_W = DATA_W + 13;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;

    logic [2:0]         r_bank, r_last_bank, r_infl_bank;
    logic [8:0]         r_addr, r_stop;
    logic               r_err;
    logic               r_inflight;
    logic [11:0]        r_infl_idx;
    logic               r_infl_last;
    logic [1:0]         r_count;
    logic [ENT_W-1:0]   r_slot0, r_slot1;

    logic [2:0]         w_first, w_lastb;
    logic               w_desc_err;
    logic               w_pop, w_push, w_issue, w_at_stop;
    logic [DATA_W-1:0]  w_rd_word;
    logic [ENT_W-1:0]   w_new;

    // Lowest and highest enabled bank of the incoming descriptor.
    always_comb begin
        w_first = '0;
        w_lastb = '0;
        for (int b = 0; b < 8; b++) begin
            if (i_bank_en[7-b]) w_first = 3'(7 - b);
            if (i_bank_en[b])   w_lastb = 3'(b);
        end
    end

    assign w_desc_err = (i_bank_en == 8'd0) ||
                        ((w_first == w_lastb) && (i_ram_stop < i_ram_start));

    assign o_feat_valid = (r_count != 2'd0);
    assign w_pop        = o_feat_valid && i_feat_ready;
    assign w_push       = r_inflight;
    assign w_at_stop    = (r_bank == r_last_bank) && (r_addr == r_stop);

    // Issue only when the word cannot overflow the buffer once it returns.
    assign w_issue = (r_state == S_RUN) &&
                     ((3'(r_count) + 3'(r_inflight) - 3'(w_pop)) < 3'd2);

    assign w_rd_word = i_ram_rdata[32'(r_infl_bank) * DATA_W +: DATA_W];
    assign w_new     = {r_infl_last, r_infl_idx, w_rd_word};

    assign o_feat_last = r_slot0[ENT_W-1];
    assign o_feat_idx  = r_slot0[ENT_W-2 -: 12];
    assign o_feat_data = r_slot0[DATA_W-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = w_desc_err ? S_DONE : S_RUN;
            S_RUN:   if (w_issue && w_at_stop) w_next = S_DRAIN;
            // Finish as soon as the final beat is being accepted.
            S_DRAIN: if (!r_inflight &&
                         ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                         w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        o_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
        o_done     = (r_state == S_DONE);
        o_err      = (r_state == S_DONE) && r_err;
        o_ram_en   = w_issue ? (8'd1 << r_bank) : 8'd0;
        o_ram_addr = r_addr;
    end

    // Address walk, in-flight tracking and output buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank      <= '0;
            r_addr      <= '0;
            r_last_bank <= '0;
            r_stop      <= '0;
            r_err       <= 1'b0;
            r_inflight  <= 1'b0;
            r_infl_bank <= '0;
            r_infl_idx  <= '0;
            r_infl_last <= 1'b0;
            r_count     <= '0;
            r_slot0     <= '0;
            r_slot1     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_bank      <= w_first;
                r_addr      <= i_ram_start;
                r_last_bank <= w_lastb;
                r_stop      <= i_ram_stop;
                r_err       <= w_desc_err;
            end else if (w_issue && !w_at_stop) begin
                if (r_addr == 9'd511) begin
                    r_addr <= '0;
                    r_bank <= 3'(r_bank + 3'd1);
                end else begin
                    r_addr <= 9'(r_addr + 9'd1);
                end
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_bank <= r_bank;
                r_infl_idx  <= {r_bank, r_addr};
                r_infl_last <= w_at_stop;
            end

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_slot0 <= w_new;
                    else                 r_slot1 <= w_new;
                    r_count <= 2'(r_count + 2'd1);
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= 2'(r_count - 2'd1);
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
